// File: rtl/axi_stream_output_sched.sv
// -----------------------------------------------------------------------------
// axi_stream_output_sched
//
// Round-robin scheduler sharing one AXI-Stream output serializer between NREQ
// result producers. The winning producer's N-character vector is latched into
// a local buffer and presented on out_d while out_run is high. Once the
// serializer reports valid, run drops for at least one cycle so its character
// counter clears before the next transfer.
//
// Ports:
//   ACLK       in   clock, rising edge
//   ARESET     in   asynchronous reset, active-high
//   req        in   [NREQ]     level request per producer
//   d_in       in   [NREQ*DW]  producer vectors, requester i at [i*DW +: DW]
//   ack        out  [NREQ]     one-cycle pulse: requester's d_in captured
//   done       out  [NREQ]     one-cycle pulse: requester's vector written
//   out_run    out  1          serializer run
//   out_d      out  [DW]       serializer data, registered buffer
//   out_valid  in   1          serializer valid (all N chars written)
//   busy       out  1          high in RUN or DONE
//   grant_id   out  [IDW]      index of current/last granted requester
// -----------------------------------------------------------------------------
`ifndef N
`define N 4
`endif
`ifndef CHAR_LEN
`define CHAR_LEN 8
`endif

module axi_stream_output_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*`N*`CHAR_LEN-1:0]  d_in,
   output logic [NREQ-1:0]               ack,
   output logic [NREQ-1:0]               done,
   output logic                          out_run,
   output logic [`N*`CHAR_LEN-1:0]       out_d,
   input  logic                          out_valid,
   output logic                          busy,
   output logic [IDW-1:0]                grant_id
);

   localparam int DW = `N * `CHAR_LEN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;

   // Arbitration result
   logic             found;
   logic [IDW-1:0]   sel;

   // Next values of the registered outputs
   logic [NREQ-1:0]  ack_nxt, done_nxt;
   logic             run_nxt, busy_nxt;
   logic [DW-1:0]    d_nxt;
   logic [IDW-1:0]   gid_nxt;

   // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
   // The requester just served sits at ptr-1 and is therefore visited last.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            sel   = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   // State register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next-state logic. IDLE and DONE both arbitrate; DONE->RUN gives
   // back-to-back transfers with exactly one run-low cycle between them.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = found ? RUN : IDLE;
         RUN:        if (out_valid) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs.
   always_comb begin
      ack_nxt  = '0;
      done_nxt = '0;
      run_nxt  = 1'b0;
      d_nxt    = out_d;
      gid_nxt  = grant_id;
      ptr_nxt  = ptr;
      case (state)
         IDLE, DONE: begin
            if (found) begin
               gid_nxt      = sel;
               d_nxt        = d_in[int'(sel)*DW +: DW];
               ack_nxt[sel] = 1'b1;
               ptr_nxt      = IDW'((int'(sel) + 1) % NREQ);
               run_nxt      = 1'b1;
            end
         end
         RUN: begin
            // req is ignored here; the buffer holds until the serializer is done
            if (out_valid) done_nxt[grant_id] = 1'b1;
            else           run_nxt            = 1'b1;
         end
         default: ;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Output registers; reset abandons any transfer in flight without a done.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ack      <= '0;
         done     <= '0;
         out_run  <= 1'b0;
         out_d    <= '0;
         busy     <= 1'b0;
         grant_id <= '0;
      end else begin
         ack      <= ack_nxt;
         done     <= done_nxt;
         out_run  <= run_nxt;
         out_d    <= d_nxt;
         busy     <= busy_nxt;
         grant_id <= gid_nxt;
      end
   end

endmodule

// File: tb/tb_axi_stream_output_sched.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_output_sched
//
// Randomized producers and a serializer model drive the scheduler. A monitor
// predicts each grant from a round-robin reference model, pushes the expected
// completion into a scoreboard and pops it when done is presented.
// -----------------------------------------------------------------------------
`ifndef N
`define N 4
`endif
`ifndef CHAR_LEN
`define CHAR_LEN 8
`endif

module tb_axi_stream_output_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int DW   = `N * `CHAR_LEN;

   logic                 ACLK = 1'b0;
   logic                 ARESET;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   d_in;
   logic [NREQ-1:0]      ack, done;
   logic                 out_run, out_valid, busy;
   logic [DW-1:0]        out_d;
   logic [IDW-1:0]       grant_id;

   axi_stream_output_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .req       (req),
      .d_in      (d_in),
      .ack       (ack),
      .done      (done),
      .out_run   (out_run),
      .out_d     (out_d),
      .out_valid (out_valid),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] rand_vec();
      logic [DW-1:0] v;
      for (int b = 0; b < DW; b += 32) v = (v << 32) | DW'($urandom);
      return v;
   endfunction

   // Spec rule: first requester searching ptr, ptr+1, ... modulo NREQ
   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // ---------------- stimulus knobs ----------------
   logic [NREQ-1:0] mask;
   int req_pct, hold_pct, lat_min, lat_max, spur_pct;
   int ser_cnt, ser_lat;

   // Producers and serializer model, updated on the falling edge
   always @(negedge ACLK) begin
      if (ARESET) begin
         req       = '0;
         out_valid = 1'b0;
         ser_cnt   = 0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if (ack[i]) begin
                  if (int'($urandom_range(99)) < hold_pct) d_in[i*DW +: DW] = rand_vec();
                  else                                     req[i] = 1'b0;
               end
            end else if (mask[i] && int'($urandom_range(99)) < req_pct) begin
               req[i]           = 1'b1;
               d_in[i*DW +: DW] = rand_vec();
            end
         end
         if (out_run) begin
            ser_cnt++;
            if (ser_cnt == 1) ser_lat = int'($urandom_range(lat_max, lat_min));
            out_valid = (ser_cnt >= ser_lat);
         end else begin
            ser_cnt   = 0;
            out_valid = (int'($urandom_range(99)) < spur_pct);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   model_ptr = 0;
   int   sel;
   bit   busy_p = 1'b0, done_p = 1'b0, arb;

   always @(posedge ACLK) begin
      #1;
      if (ARESET) begin
         sb.delete();
         model_ptr = 0;
         busy_p    = 1'b0;
         done_p    = 1'b0;
      end else begin
         // Previous cycle was IDLE (not busy) or DONE (done pulse visible)
         arb = !busy_p || done_p;
         if (arb) begin
            check("done_outside_run", done, 0);
            if (req != 0) begin
               sel = rr_pick(req, model_ptr);
               check("ack_grant", ack, 64'(1) << sel);
               check("grant_id", grant_id, sel);
               check("out_d_capture", out_d, d_in[sel*DW +: DW]);
               check("run_on_grant", out_run, 1);
               check("busy_on_grant", busy, 1);
               sb.push_back('{idx: sel, data: d_in[sel*DW +: DW]});
               model_ptr = (sel + 1) % NREQ;
            end else begin
               check("ack_idle", ack, 0);
               check("run_idle", out_run, 0);
               check("busy_idle", busy, 0);
            end
         end else begin
            check("ack_in_run", ack, 0);
            if (sb.size() != 1) begin
               check("sb_depth", sb.size(), 1);
            end else if (out_valid) begin
               e = sb.pop_front();
               check("done_pulse", done, 64'(1) << e.idx);
               check("run_drop", out_run, 0);
               check("busy_done", busy, 1);
            end else begin
               check("done_in_run", done, 0);
               check("run_held", out_run, 1);
               check("out_d_stable", out_d, sb[0].data);
            end
         end
         busy_p = busy;
         done_p = (done != 0);
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(posedge ACLK);
   endtask

   task automatic set_knobs(input logic [NREQ-1:0] m, input int rp, input int hp,
                            input int lmin, input int lmax, input int sp);
      mask = m; req_pct = rp; hold_pct = hp; lat_min = lmin; lat_max = lmax; spur_pct = sp;
   endtask

   initial begin
      int t;
      ARESET    = 1'b1;
      req       = '0;
      d_in      = '0;
      out_valid = 1'b0;
      ser_lat   = `N;
      set_knobs('0, 0, 0, `N, `N, 0);
      run_cycles(3);
      @(negedge ACLK); #2;
      ARESET = 1'b0;
      @(posedge ACLK); #2;
      check("rst_out_run", out_run, 0);
      check("rst_out_d", out_d, 0);
      check("rst_ack", ack, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);

      // Single requester
      set_knobs(4'b0100, 30, 0, `N, `N, 0);
      run_cycles(200);
      // All requesters held high: strict rotation, one run-low cycle between
      set_knobs(4'b1111, 100, 100, `N, `N, 0);
      run_cycles(150);
      // Rotation skipping
      set_knobs(4'b0011, 50, 30, 1, `N, 0);
      run_cycles(200);
      set_knobs(4'b0010, 50, 30, 1, `N, 0);
      run_cycles(100);
      // Backpressure: long serializer latency with requests arriving meanwhile
      set_knobs(4'b1111, 60, 50, 40, 40, 0);
      run_cycles(600);
      // Random mix including spurious valid outside RUN
      set_knobs(4'b1111, 20, 30, 1, 12, 20);
      run_cycles(3000);

      // Reset in the middle of a transfer
      set_knobs(4'b1111, 50, 0, 20, 20, 0);
      t = 0;
      while (!out_run && t < 500) begin
         @(posedge ACLK); #1;
         t++;
      end
      check("reach_run", out_run, 1);
      @(posedge ACLK); #3;
      ARESET = 1'b1;
      #1;
      check("mid_rst_out_run", out_run, 0);
      check("mid_rst_out_d", out_d, 0);
      check("mid_rst_ack", ack, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant_id", grant_id, 0);
      run_cycles(2);
      // All four request together after release: pointer must be back at 0
      set_knobs(4'b1111, 100, 0, `N, `N, 0);
      @(negedge ACLK); #2;
      ARESET = 1'b0;
      run_cycles(100);

      // Drain
      set_knobs('0, 0, 0, 1, `N, 0);
      t = 0;
      while ((busy || req != 0) && t < 500) begin
         @(posedge ACLK); #2;
         t++;
      end
      run_cycles(2);
      #2;
      check("drain_busy", busy, 0);
      check("drain_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
